// File: rtl/chess_pkg.sv
// Shared types and helpers for the move-check front end: piece codes,
// sequencer states and small coordinate arithmetic.
package chess_pkg;

    typedef enum logic [2:0] {
        PT_EMPTY   = 3'd0,
        PT_PAWN    = 3'd1,
        PT_KNIGHT  = 3'd2,
        PT_BISHOP  = 3'd3,
        PT_ROOK    = 3'd4,
        PT_QUEEN   = 3'd5,
        PT_KING    = 3'd6,
        PT_INVALID = 3'd7
    } piece_type_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SCREEN   = 3'd1,
        S_SCAN     = 3'd2,
        S_DISPATCH = 3'd3,
        S_WAIT     = 3'd4,
        S_RESP     = 3'd5
    } seq_state_t;

    localparam int         COLOUR_BIT = 3;
    localparam logic [3:0] EMPTY      = 4'h0;

    function automatic logic [2:0] abs_diff(input logic [2:0] a, input logic [2:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // -1 is encoded as 3'b111 so that cursor + step wraps like a signed add
    function automatic logic [2:0] step_dir(input logic [2:0] from, input logic [2:0] to);
        if (to > from)
            return 3'd1;
        else if (to < from)
            return 3'd7;
        else
            return 3'd0;
    endfunction

endpackage

// File: rtl/path_scanner.sv
// Walks a sliding piece's path one square per cycle and flags the first
// occupied intermediate square or arrival at the destination.
module path_scanner
    import chess_pkg::*;
(
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  run,
    input  logic [2:0]            old_x,
    input  logic [2:0]            old_y,
    input  logic [2:0]            new_x,
    input  logic [2:0]            new_y,
    input  logic [7:0][7:0][3:0]  board_in,
    output logic                  clear,
    output logic                  blocked
);

    logic [2:0] cur_x, cur_y;
    logic [2:0] step_x, step_y;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            cur_x  <= '0;
            cur_y  <= '0;
            step_x <= '0;
            step_y <= '0;
        end else if (start) begin
            step_x <= step_dir(old_x, new_x);
            step_y <= step_dir(old_y, new_y);
            cur_x  <= old_x + step_dir(old_x, new_x);
            cur_y  <= old_y + step_dir(old_y, new_y);
        end else if (run && !clear && !blocked) begin
            cur_x <= cur_x + step_x;
            cur_y <= cur_y + step_y;
        end
    end

    // The destination square itself is never treated as a blocker
    assign clear   = (cur_x == new_x) && (cur_y == new_y);
    assign blocked = !clear && (board_in[cur_x][cur_y] != EMPTY);

endmodule

// File: rtl/move_check_sequencer.sv
// Screens a move request, scans sliding paths, dispatches to one piece checker
// and returns a legal/illegal verdict. CHECK_TIMEOUT_EN adds a checker watchdog.
module move_check_sequencer
    import chess_pkg::*;
#(
    parameter int NUM_CHECKERS   = 6,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    CLOCK_50,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [2:0]              old_x,
    input  logic [2:0]              old_y,
    input  logic [2:0]              new_x,
    input  logic [2:0]              new_y,
    input  logic [7:0][7:0][3:0]    board_in,
    output logic [NUM_CHECKERS-1:0] chk_start,
    output logic [2:0]              chk_h_delta,
    output logic [2:0]              chk_v_delta,
    output logic [3:0]              chk_piece,
    input  logic [NUM_CHECKERS-1:0] chk_move_valid,
    input  logic [NUM_CHECKERS-1:0] chk_done,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_legal,
    output logic                    rsp_error
);

    seq_state_t  state;
    logic [2:0]  ox_q, oy_q, nx_q, ny_q;
    logic [2:0]  h_q, v_q;
    logic [3:0]  src_q, dst_q;
    logic        legal_q;
    piece_type_t src_type;
    logic [NUM_CHECKERS-1:0] sel;
    logic        reject, slider, on_line, scan_go;
    logic        done_hit, valid_hit, timeout;
    logic        scan_clear, scan_blocked;

    assign src_type = piece_type_t'(src_q[2:0]);
    assign sel      = {{(NUM_CHECKERS-1){1'b0}}, 1'b1} << (src_q[2:0] - 3'd1);

    assign reject   = (src_type == PT_EMPTY) || (src_type == PT_INVALID)
                   || ((ox_q == nx_q) && (oy_q == ny_q))
                   || ((dst_q != EMPTY) && (dst_q[COLOUR_BIT] == src_q[COLOUR_BIT]));
    assign slider   = src_type inside {PT_BISHOP, PT_ROOK, PT_QUEEN};
    assign on_line  = (h_q == v_q) || (h_q == 3'd0) || (v_q == 3'd0);
    // Off-line slider moves go straight to the checker, which rejects them
    assign scan_go  = slider && on_line;

    assign done_hit  = |(chk_done & sel);
    assign valid_hit = |(chk_move_valid & sel);

    path_scanner u_scan (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .start    (state == S_SCREEN && !reject && scan_go),
        .run      (state == S_SCAN),
        .old_x    (ox_q),
        .old_y    (oy_q),
        .new_x    (nx_q),
        .new_y    (ny_q),
        .board_in (board_in),
        .clear    (scan_clear),
        .blocked  (scan_blocked)
    );

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            ox_q    <= '0;
            oy_q    <= '0;
            nx_q    <= '0;
            ny_q    <= '0;
            h_q     <= '0;
            v_q     <= '0;
            src_q   <= EMPTY;
            dst_q   <= EMPTY;
            legal_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    ox_q    <= old_x;
                    oy_q    <= old_y;
                    nx_q    <= new_x;
                    ny_q    <= new_y;
                    h_q     <= abs_diff(new_x, old_x);
                    v_q     <= abs_diff(new_y, old_y);
                    src_q   <= board_in[old_x][old_y];
                    dst_q   <= board_in[new_x][new_y];
                    legal_q <= 1'b0;
                    state   <= S_SCREEN;
                end
                S_SCREEN: begin
                    if (reject)
                        state <= S_RESP;
                    else if (scan_go)
                        state <= S_SCAN;
                    else
                        state <= S_DISPATCH;
                end
                S_SCAN: begin
                    if (scan_clear)
                        state <= S_DISPATCH;
                    else if (scan_blocked)
                        state <= S_RESP;
                end
                S_DISPATCH: state <= S_WAIT;
                S_WAIT: begin
                    if (done_hit) begin
                        legal_q <= valid_hit;
                        state   <= S_RESP;
                    end else if (timeout) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: if (rsp_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CHECK_TIMEOUT_EN
    logic [7:0] wd_cnt;
    logic       err_q;

    assign timeout = (state == S_WAIT) && !done_hit && (wd_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            wd_cnt <= (state == S_WAIT) ? wd_cnt + 8'd1 : 8'd0;
            if (state == S_IDLE && req_valid)
                err_q <= 1'b0;
            else if (timeout)
                err_q <= 1'b1;
        end
    end

    assign rsp_error = rsp_valid && err_q;
`else
    assign timeout   = 1'b0;
    assign rsp_error = 1'b0;
`endif

    assign req_ready   = (state == S_IDLE);
    assign rsp_valid   = (state == S_RESP);
    assign rsp_legal   = rsp_valid && legal_q;
    assign chk_start   = (state == S_DISPATCH) ? sel : '0;
    assign chk_h_delta = h_q;
    assign chk_v_delta = v_q;
    assign chk_piece   = src_q;

endmodule

// File: tb/tb_move_check_sequencer.sv
// Scoreboard bench for move_check_sequencer: directed moves, a responding
// checker model, reset-in-scan and response back-pressure.
module tb_move_check_sequencer;

    logic               CLOCK_50;
    logic               reset_n;
    logic               req_valid, req_ready;
    logic [2:0]         old_x, old_y, new_x, new_y;
    logic [7:0][7:0][3:0] board;
    logic [5:0]         chk_start, chk_move_valid, chk_done;
    logic [2:0]         chk_h_delta, chk_v_delta;
    logic [3:0]         chk_piece;
    logic               rsp_valid, rsp_ready, rsp_legal, rsp_error;

    move_check_sequencer dut (
        .CLOCK_50       (CLOCK_50),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .old_x          (old_x),
        .old_y          (old_y),
        .new_x          (new_x),
        .new_y          (new_y),
        .board_in       (board),
        .chk_start      (chk_start),
        .chk_h_delta    (chk_h_delta),
        .chk_v_delta    (chk_v_delta),
        .chk_piece      (chk_piece),
        .chk_move_valid (chk_move_valid),
        .chk_done       (chk_done),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_legal      (rsp_legal),
        .rsp_error      (rsp_error)
    );

    typedef struct packed { logic err; logic legal; } rsp_t;
    rsp_t exp_q[$];

    int n_checks = 0, n_fail = 0;
    int cyc = 0, acc_cyc = 0, rsp_cyc = 0, n_start = 0;
    logic [5:0] last_start = '0;
    logic rsp_seen = 1'b0;
    int   chk_lat = 0;
    logic chk_ok = 1'b0;
    logic [5:0] m_sel;

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    initial forever begin
        @(posedge CLOCK_50);
        cyc++;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: start pulses, first-valid cycle, and scoreboard pops on handshake
    initial forever begin
        rsp_t e;
        @(negedge CLOCK_50);
        if (reset_n) begin
            if (|chk_start) begin
                n_start++;
                last_start = chk_start;
            end
            if (rsp_valid && !rsp_seen) begin
                rsp_seen = 1'b1;
                rsp_cyc  = cyc;
            end
            if (!rsp_valid) rsp_seen = 1'b0;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got legal=%0b error=%0b with nothing expected", rsp_legal, rsp_error);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_legal", 32'(rsp_legal), 32'(e.legal));
                    check("rsp_error", 32'(rsp_error), 32'(e.err));
                end
            end
        end
    end

    // Checker model: answers chk_lat cycles after start, with distractor done/valid on other indices
    initial begin
        chk_done = '0;
        chk_move_valid = '0;
        forever begin
            @(negedge CLOCK_50);
            if (reset_n && (|chk_start) && chk_lat > 0) begin
                m_sel = chk_start;
                if (chk_lat > 1) begin
                    repeat (chk_lat - 1) @(posedge CLOCK_50);
                    #1 chk_done = ~m_sel;
                    chk_move_valid = ~m_sel;
                end
                @(posedge CLOCK_50);
                #1 chk_done = '1;
                chk_move_valid = chk_ok ? m_sel : ~m_sel;
                @(posedge CLOCK_50);
                #1 chk_done = '0;
                chk_move_valid = '0;
            end
        end
    end

    task automatic send(input logic [2:0] ox, input logic [2:0] oy,
                        input logic [2:0] nx, input logic [2:0] ny, input string name);
        bit got = 0;
        n_start = 0;
        old_x = ox; old_y = oy; new_x = nx; new_y = ny;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK_50);
            if (req_ready) begin
                acc_cyc = cyc;
                got = 1;
                break;
            end
        end
        if (!got) check({name, "_accept_timeout"}, 32'(req_ready), 32'd1);
        @(posedge CLOCK_50);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge CLOCK_50);
            if (exp_q.size() == 0) break;
        end
        if (exp_q.size() != 0) begin
            check({name, "_rsp_timeout"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_req(input logic [2:0] ox, input logic [2:0] oy,
                          input logic [2:0] nx, input logic [2:0] ny,
                          input logic exp_legal, input logic exp_err, input int exp_lat,
                          input int exp_starts, input logic [5:0] exp_sel,
                          input logic [2:0] exp_h, input logic [2:0] exp_v, input string name);
        rsp_t e;
        e.legal = exp_legal;
        e.err   = exp_err;
        exp_q.push_back(e);
        send(ox, oy, nx, ny, name);
        drain(name);
        check({name, "_latency"}, 32'(rsp_cyc - acc_cyc), 32'(exp_lat));
        check({name, "_starts"}, 32'(n_start), 32'(exp_starts));
        if (exp_starts > 0) check({name, "_start_sel"}, 32'(last_start), 32'(exp_sel));
        check({name, "_h_delta"}, 32'(chk_h_delta), 32'(exp_h));
        check({name, "_v_delta"}, 32'(chk_v_delta), 32'(exp_v));
        check({name, "_piece"}, 32'(chk_piece), 32'(board[ox][oy]));
    endtask

    task automatic pulse_reset();
        #1 reset_n = 1'b0;
        @(posedge CLOCK_50);
        #1 reset_n = 1'b1;
        @(posedge CLOCK_50);
        #1;
    endtask

    initial begin
        rsp_t e;
        bit got;
        reset_n = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        old_x = '0; old_y = '0; new_x = '0; new_y = '0;
        board = '0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_chk_start", 32'(chk_start), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_legal", 32'(rsp_legal), 32'd0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        check("rst_chk_piece", 32'(chk_piece), 32'd0);
        reset_n = 1'b1;
        @(posedge CLOCK_50);
        #1;

        // White bishop, clear diagonal, checker accepts after 3 cycles
        board = '0; board[2][0] = 4'h3;
        chk_lat = 3; chk_ok = 1'b1;
        do_req(3'd2, 3'd0, 3'd5, 3'd3, 1'b1, 1'b0, 9, 1, 6'b000100, 3'd3, 3'd3, "bishop_clear");

        // Same move blocked by a pawn on the second intermediate square
        board[4][2] = 4'h1;
        do_req(3'd2, 3'd0, 3'd5, 3'd3, 1'b0, 1'b0, 4, 0, 6'b000000, 3'd3, 3'd3, "bishop_blocked");

        // Empty source square
        board = '0;
        do_req(3'd0, 3'd0, 3'd3, 3'd3, 1'b0, 1'b0, 2, 0, 6'b000000, 3'd3, 3'd3, "empty_src");

        // Rook onto a friendly piece
        board[0][0] = 4'h4; board[0][5] = 4'h1;
        do_req(3'd0, 3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 2, 0, 6'b000000, 3'd0, 3'd5, "rook_friendly");

        // Rook captures a black pawn along a clear file
        board[0][5] = 4'h9;
        chk_lat = 1; chk_ok = 1'b1;
        do_req(3'd0, 3'd0, 3'd0, 3'd5, 1'b1, 1'b0, 9, 1, 6'b001000, 3'd0, 3'd5, "rook_capture");

        // Same square source and destination
        do_req(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 2, 0, 6'b000000, 3'd0, 3'd0, "null_move");

        // Queen off-line move skips the scan; checker rejects it
        board = '0; board[3][3] = 4'h5;
        chk_lat = 1; chk_ok = 1'b0;
        do_req(3'd3, 3'd3, 3'd4, 3'd5, 1'b0, 1'b0, 4, 1, 6'b010000, 3'd1, 3'd2, "queen_offline");

        // Knight, checker says illegal while other indices claim valid
        board = '0; board[1][0] = 4'h2;
        chk_lat = 2; chk_ok = 1'b0;
        do_req(3'd1, 3'd0, 3'd2, 3'd2, 1'b0, 1'b0, 5, 1, 6'b000010, 3'd1, 3'd2, "knight_reject");

        // Knight with a checker that never answers
        chk_lat = 0;
`ifdef CHECK_TIMEOUT_EN
        do_req(3'd1, 3'd0, 3'd2, 3'd2, 1'b0, 1'b1, 19, 1, 6'b000010, 3'd1, 3'd2, "knight_timeout");
`else
        send(3'd1, 3'd0, 3'd2, 3'd2, "knight_hang");
        repeat (100) @(negedge CLOCK_50);
        check("hang_rsp_valid", 32'(rsp_valid), 32'd0);
        check("hang_req_ready", 32'(req_ready), 32'd0);
        check("hang_starts", 32'(n_start), 32'd1);
        pulse_reset();
`endif

        // Reset while the rook is scanning a long file
        board = '0; board[0][0] = 4'h4;
        send(3'd0, 3'd0, 3'd0, 3'd7, "scan_reset");
        @(posedge CLOCK_50);
        #1;
        check("scan_busy", 32'(req_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        check("scan_rst_req_ready", 32'(req_ready), 32'd1);
        check("scan_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("scan_rst_chk_start", 32'(chk_start), 32'd0);
        check("scan_rst_chk_piece", 32'(chk_piece), 32'd0);
        check("scan_rst_v_delta", 32'(chk_v_delta), 32'd0);
        @(posedge CLOCK_50);
        #1 reset_n = 1'b1;
        @(posedge CLOCK_50);
        #1;

        // New request after reset, response held under back-pressure
        board[0][7] = 4'hB;
        chk_lat = 2; chk_ok = 1'b1;
        rsp_ready = 1'b0;
        e.legal = 1'b1; e.err = 1'b0;
        exp_q.push_back(e);
        send(3'd0, 3'd0, 3'd0, 3'd7, "hold");
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLOCK_50);
            if (rsp_valid) begin got = 1; break; end
        end
        check("hold_rsp_seen", 32'(got), 32'd1);
        check("hold_latency", 32'(rsp_cyc - acc_cyc), 32'd12);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLOCK_50);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_legal", 32'(rsp_legal), 32'd1);
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_v_delta", 32'(chk_v_delta), 32'd7);
            check("hold_piece", 32'(chk_piece), 32'h4);
        end
        @(posedge CLOCK_50);
        #1 rsp_ready = 1'b1;
        drain("hold");
        check("hold_starts", 32'(n_start), 32'd1);
        check("hold_start_sel", 32'(last_start), 32'(6'b001000));
        check("post_req_ready", 32'(req_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
